mem_bus_bridge: RTL



---
 rtl/mem_bus_pkg.sv | 16 +
 rtl/bus_timeout_counter.sv | 40 ++++
 rtl/mem_bus_bridge.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the core-to-fabric memory bridge: FSM encoding,
// default widths and the default bus timeout.
package mem_bus_pkg;

    localparam int MB_ADDR_WIDTH = 32;
    localparam int MB_DATA_WIDTH = 32;
    localparam int MB_TIMEOUT    = 255;
    localparam int MB_CNT_WIDTH  = 8;

    typedef enum logic [1:0] {
        MB_IDLE = 2'b00,
        MB_REQ  = 2'b01,
        MB_DONE = 2'b10
    } mb_state_e;

endpackage

// File: rtl/bus_timeout_counter.sv
// Saturating 8-bit cycle counter that flags when it has reached the
// configured bus timeout.
module bus_timeout_counter
    import mem_bus_pkg::*;
#(
    parameter int TIMEOUT = MB_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [MB_CNT_WIDTH-1:0] LIMIT   = TIMEOUT[MB_CNT_WIDTH-1:0];
    localparam logic [MB_CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [MB_CNT_WIDTH-1:0] count_q;
    logic [MB_CNT_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == LIMIT);

endmodule

// File: rtl/mem_bus_bridge.sv
// Turns the core's single-strobe read/write requests into one valid/ready
// bus transaction each, stalling the core until the response is back.
module mem_bus_bridge
    import mem_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = MB_ADDR_WIDTH,
    parameter int DATA_WIDTH = MB_DATA_WIDTH,
    parameter int TIMEOUT    = MB_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  core_read,
    input  logic                  core_write,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic [DATA_WIDTH-1:0] core_rdata,
    output logic                  core_stall,
    output logic                  core_error,
    output logic                  bus_valid,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic                  bus_ready,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    input  logic                  bus_err,
    output logic [1:0]            dbg_state
);

    // Bus handshake: bus_valid is high for every REQ cycle and the request
    // fields stay frozen until the slave answers with bus_ready in the same
    // cycle (or the bridge gives up on timeout); no back-pressure otherwise.

    mb_state_e             state_q, state_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  error_q, error_d;

    logic req;
    logic start;
    logic in_req;
    logic expired;

    assign req    = core_read | core_write;
    assign start  = (state_q == MB_IDLE) && req;
    assign in_req = (state_q == MB_REQ);

    // Counter holds the index of the current REQ cycle (1 in the first one).
    bus_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!in_req && !start),
        .enable  (in_req || start),
        .expired (expired)
    );

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        error_d = 1'b0;
        case (state_q)
            MB_IDLE: begin
                if (req) begin
                    state_d = MB_REQ;
                    addr_d  = core_addr;
                    wdata_d = core_wdata;
                    we_d    = core_write;
                end
            end
            MB_REQ: begin
                if (bus_ready) begin
                    state_d = MB_DONE;
                    error_d = bus_err;
                    if (!we_q) begin
                        rdata_d = bus_rdata;
                    end
                end else if (expired) begin
                    state_d = MB_DONE;
                    error_d = 1'b1;
                    rdata_d = '0;
                end
            end
            MB_DONE: begin
                state_d = MB_IDLE;
            end
            default: begin
                state_d = MB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MB_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    assign core_stall = in_req || start;
    assign core_error = error_q;
    assign core_rdata = rdata_q;
    assign bus_valid  = in_req;
    assign bus_we     = we_q;
    assign bus_addr   = addr_q;
    assign bus_wdata  = wdata_q;
    assign dbg_state  = state_q;

endmodule
